// File: rtl/wb_data_mem_slave.sv
// Wishbone classic-cycle slave data memory with programmable wait states and out-of-range error termination.
// Optional build macro WB_SEL_EN enables SEL_I byte-lane write masking.
module wb_data_mem_slave #(
    parameter int unsigned AW          = 8,
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    input  logic [AW-1:0] ADR_I,
    input  logic [31:0]   DAT_I,
`ifdef WB_SEL_EN
    input  logic [3:0]    SEL_I,
`endif
    output logic [31:0]   DAT_O,
    output logic          ACK_O,
    output logic          ERR_O
);

    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = DW / 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned XAW   = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic             we;
        logic [AW-1:0]    adr;
        logic [DW-1:0]    dat;
        logic [LANES-1:0] sel;
    } req_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_new_c;
    logic          req_c;
    logic          load_c;
    logic          resp_c;
    logic          in_range_c;
    logic          wr_c;

    logic [DW-1:0] mem [MEM_WORDS];

    assign req_c      = CYC_I & STB_I;
    assign resp_c     = (state_q == S_RESP);
    assign in_range_c = ({1'b0, req_q.adr} < XAW'(MEM_WORDS));
    assign wr_c       = resp_c & in_range_c & req_q.we & ~rst;

    // Request snapshot taken in IDLE; lanes default to the full word when byte selects are not built in
    always_comb begin
        req_new_c     = '0;
        req_new_c.we  = WE_I;
        req_new_c.adr = ADR_I;
        req_new_c.dat = DAT_I;
`ifdef WB_SEL_EN
        req_new_c.sel = SEL_I;
`else
        req_new_c.sel = '1;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a dropped request during WAIT abandons the transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    load_c  = 1'b1;
                    cnt_d   = CW'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req_c) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered response: terminations are single-cycle pulses issued as RESP completes
    always_ff @(posedge clk) begin
        if (rst) begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            DAT_O <= '0;
            req_q <= '0;
        end else begin
            ACK_O <= resp_c & in_range_c;
            ERR_O <= resp_c & ~in_range_c;
            if (load_c) begin
                req_q <= req_new_c;
            end
            if (resp_c && in_range_c && !req_q.we) begin
                DAT_O <= mem[req_q.adr];
            end
        end
    end

    // RAM write port, byte-lane masked; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_c) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (req_q.sel[l]) begin
                    mem[req_q.adr][8*l +: 8] <= req_q.dat[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_data_mem_slave.sv
// Directed self-checking bench for wb_data_mem_slave: instance 0 (200 words, 1 wait state),
// instance 1 (256 words, 3 wait states); byte-lane test only when WB_SEL_EN is defined.
module tb_wb_data_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [7:0]  adr   [2];
    logic [31:0] dat_i [2];
    logic [31:0] dat_o [2];
    logic        ack   [2];
    logic        err   [2];
`ifdef WB_SEL_EN
    logic [3:0]  sel   [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_data_mem_slave #(.AW(8), .MEM_WORDS(200), .WAIT_STATES(1)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .CYC_I (cyc[0]),
        .STB_I (stb[0]),
        .WE_I  (we[0]),
        .ADR_I (adr[0]),
        .DAT_I (dat_i[0]),
`ifdef WB_SEL_EN
        .SEL_I (sel[0]),
`endif
        .DAT_O (dat_o[0]),
        .ACK_O (ack[0]),
        .ERR_O (err[0])
    );

    wb_data_mem_slave #(.AW(8), .MEM_WORDS(256), .WAIT_STATES(3)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .CYC_I (cyc[1]),
        .STB_I (stb[1]),
        .WE_I  (we[1]),
        .ADR_I (adr[1]),
        .DAT_I (dat_i[1]),
`ifdef WB_SEL_EN
        .SEL_I (sel[1]),
`endif
        .DAT_O (dat_o[1]),
        .ACK_O (ack[1]),
        .ERR_O (err[1])
    );

    // One transfer; lat counts rising edges after the sampling edge until ACK/ERR is seen
    task automatic xfer(input int idx, input logic w, input logic [7:0] a, input logic [31:0] d,
                        output int lat, output logic ga, output logic ge, output logic [31:0] rd);
        @(negedge clk);
        cyc[idx] = 1'b1; stb[idx] = 1'b1; we[idx] = w; adr[idx] = a; dat_i[idx] = d;
        ga = 1'b0; ge = 1'b0; rd = '0; lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ack[idx] === 1'b1 || err[idx] === 1'b1) begin
                ga = ack[idx]; ge = err[idx]; rd = dat_o[idx];
                break;
            end
        end
        cyc[idx] = 1'b0; stb[idx] = 1'b0; we[idx] = 1'b0;
        total++;
        if (!(ga || ge)) begin
            bad++;
            $display("FAIL xfer_timeout idx=%0d adr=%h got no response, required ACK or ERR", idx, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; dat_i[i] = '0;
`ifdef WB_SEL_EN
            sel[i] = 4'hF;
`endif
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++; if (ack[i] !== 1'b0) begin bad++; $display("FAIL reset_ack%0d got=%b want=0", i, ack[i]); end
            total++; if (err[i] !== 1'b0) begin bad++; $display("FAIL reset_err%0d got=%b want=0", i, err[i]); end
            total++; if (dat_o[i] !== 32'h0) begin bad++; $display("FAIL reset_dat%0d got=%h want=0", i, dat_o[i]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_write_latency();
        int lat; logic ga, ge; logic [31:0] rd;
        xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, lat, ga, ge, rd);
        total++; if (ga !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b want=1", ga); end
        total++; if (lat != 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", lat); end
        @(negedge clk);
        total++; if (ack[0] !== 1'b0) begin bad++; $display("FAIL wr_ack_width got=%b want=0", ack[0]); end
    endtask

    task automatic test_read();
        int lat; logic ga, ge; logic [31:0] rd;
        xfer(0, 1'b0, 8'h10, 32'h0, lat, ga, ge, rd);
        total++; if (ga !== 1'b1 || ge !== 1'b0) begin bad++; $display("FAIL rd_ack got=%b%b want=10", ga, ge); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rd); end
        @(negedge clk);
        total++; if (dat_o[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%h want=deadbeef", dat_o[0]); end
    endtask

    task automatic test_range();
        int lat; logic ga, ge; logic [31:0] rd;
        xfer(0, 1'b1, 8'd199, 32'hCAFEF00D, lat, ga, ge, rd);
        total++; if (ga !== 1'b1) begin bad++; $display("FAIL top_wr_ack got=%b want=1", ga); end
        xfer(0, 1'b0, 8'd199, 32'h0, lat, ga, ge, rd);
        total++; if (rd !== 32'hCAFEF00D || ga !== 1'b1) begin bad++; $display("FAIL top_rd got=%h ack=%b want=cafef00d ack=1", rd, ga); end
        xfer(0, 1'b0, 8'd200, 32'h0, lat, ga, ge, rd);
        total++; if (ge !== 1'b1 || ga !== 1'b0) begin bad++; $display("FAIL oor_err got ack=%b err=%b want ack=0 err=1", ga, ge); end
        total++; if (lat != 2) begin bad++; $display("FAIL oor_latency got=%0d want=2", lat); end
        total++; if (dat_o[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL oor_dat_keep got=%h want=cafef00d", dat_o[0]); end
        @(negedge clk);
        total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL oor_err_width got=%b want=0", err[0]); end
        xfer(0, 1'b1, 8'd255, 32'h01010101, lat, ga, ge, rd);
        total++; if (ge !== 1'b1 || ga !== 1'b0) begin bad++; $display("FAIL oor_wr got ack=%b err=%b want ack=0 err=1", ga, ge); end
    endtask

    task automatic test_abort();
        int lat; logic ga, ge; logic [31:0] rd; logic seen;
        xfer(1, 1'b1, 8'h20, 32'h0BADF00D, lat, ga, ge, rd);
        total++; if (lat != 4 || ga !== 1'b1) begin bad++; $display("FAIL ws3_latency got=%0d ack=%b want=4 ack=1", lat, ga); end
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h20; dat_i[1] = 32'h12345678;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); @(negedge clk); seen = seen | ack[1] | err[1]; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_resp got=%b want=0", seen); end
        xfer(1, 1'b0, 8'h20, 32'h0, lat, ga, ge, rd);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL abort_data got=%h want=0badf00d", rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic ga, ge; logic [31:0] rd; logic seen;
        xfer(0, 1'b1, 8'h30, 32'h55AA55AA, lat, ga, ge, rd);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 8'h30; dat_i[0] = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = ack[0] | err[0];
        repeat (4) begin @(posedge clk); @(negedge clk); seen = seen | ack[0] | err[0]; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_resp got=%b want=0", seen); end
        total++; if (dat_o[0] !== 32'h0) begin bad++; $display("FAIL rst_mid_dat got=%h want=0", dat_o[0]); end
        xfer(0, 1'b0, 8'h30, 32'h0, lat, ga, ge, rd);
        total++; if (rd !== 32'h55AA55AA || lat != 2) begin bad++; $display("FAIL rst_mid_read got=%h lat=%0d want=55aa55aa lat=2", rd, lat); end
    endtask

    task automatic test_back_to_back();
        int lat; logic ga, ge; logic [31:0] rd; logic [8:0] mask;
        mask = '0;
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 8'h41; dat_i[0] = 32'h0F0F0F0F;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            mask[k] = ack[0];
        end
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        total++; if (mask !== 9'b100100100) begin bad++; $display("FAIL b2b_pattern got=%b want=100100100", mask); end
        xfer(0, 1'b0, 8'h41, 32'h0, lat, ga, ge, rd);
        total++; if (rd !== 32'h0F0F0F0F) begin bad++; $display("FAIL b2b_data got=%h want=0f0f0f0f", rd); end
    endtask

`ifdef WB_SEL_EN
    task automatic test_sel();
        int lat; logic ga, ge; logic [31:0] rd;
        xfer(0, 1'b1, 8'h50, 32'hAABBCCDD, lat, ga, ge, rd);
        sel[0] = 4'b0101;
        xfer(0, 1'b1, 8'h50, 32'h11223344, lat, ga, ge, rd);
        sel[0] = 4'b0000;
        xfer(0, 1'b0, 8'h50, 32'h0, lat, ga, ge, rd);
        total++; if (rd !== 32'hAA22CC44) begin bad++; $display("FAIL sel_merge got=%h want=aa22cc44", rd); end
        xfer(0, 1'b1, 8'h50, 32'hFFFFFFFF, lat, ga, ge, rd);
        total++; if (ga !== 1'b1) begin bad++; $display("FAIL sel_zero_ack got=%b want=1", ga); end
        sel[0] = 4'hF;
        xfer(0, 1'b0, 8'h50, 32'h0, lat, ga, ge, rd);
        total++; if (rd !== 32'hAA22CC44) begin bad++; $display("FAIL sel_zero_keep got=%h want=aa22cc44", rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_latency();
        test_read();
        test_range();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef WB_SEL_EN
        test_sel();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
